// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one client channel at a time to a shared memory port, bounded by MAX_BURST completions.
// Define MEM_ARBITER_RR_EN to compile in round-robin arbitration selected by rr_mode.
module mem_arbiter #(
    parameter int NCH       = 4,
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_wvalid,
    output logic [NCH-1:0]    ch_wready,
    input  logic [NCH*AW-1:0] ch_waddr,
    input  logic [NCH*DW-1:0] ch_wdata,
    input  logic [NCH-1:0]    ch_rvalid,
    output logic [NCH-1:0]    ch_rready,
    input  logic [NCH*AW-1:0] ch_raddr,
    output logic [NCH*DW-1:0] ch_rdata,
    output logic              wvalid,
    input  logic              wready,
    output logic [AW-1:0]     waddr,
    output logic [DW-1:0]     wdata,
    output logic              rvalid,
    input  logic              rready,
    output logic [AW-1:0]     raddr,
    input  logic [DW-1:0]     rdata,
    input  logic [2:0]        sel,
    input  logic              rr_mode,
    output logic [NCH-1:0]    gnt,
    output logic              busy
);
    localparam int IW = $clog2(NCH);
    localparam logic [8:0] MB = 9'(MAX_BURST);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_nxt;
    logic [NCH-1:0] gnt_nxt;
    logic [7:0]     cnt, cnt_nxt;
    logic [8:0]     sum;
    logic [NCH-1:0] req;
    logic [7:0]     req8;
    logic [IW-1:0]  gidx, pick_idx;
    logic           pick_hit;

    assign req  = ch_wvalid | ch_rvalid;
    assign busy = state == BUSY;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NCH; i++)
            if (gnt[i]) gidx = IW'(i);
    end

    // Zero-padded to 8 so any sel value indexes safely; sel >= NCH sees no request.
    always_comb begin
        req8 = '0;
        req8[NCH-1:0] = req;
    end

`ifdef MEM_ARBITER_RR_EN
    logic [IW-1:0] ptr, ptr_nxt, rr_idx, rr_j;
    logic          rr_hit;

    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        rr_j   = '0;
        for (int i = 1; i <= NCH; i++) begin
            rr_j = IW'((int'(ptr) + i) % NCH);
            if (!rr_hit && req[rr_j]) begin
                rr_hit = 1'b1;
                rr_idx = rr_j;
            end
        end
    end

    always_comb begin
        pick_hit = rr_mode ? rr_hit : req8[sel];
        pick_idx = rr_mode ? rr_idx : IW'(sel);
        ptr_nxt  = (state == IDLE && rr_mode && rr_hit) ? rr_idx : ptr;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= IW'(NCH - 1);
        else ptr <= ptr_nxt;
`else
    logic unused_rr;
    assign unused_rr = rr_mode;

    always_comb begin
        pick_hit = req8[sel];
        pick_idx = IW'(sel);
    end
`endif

    // Leaving on the completion that reaches MAX_BURST keeps the 8-bit count from ever wrapping.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        cnt_nxt   = cnt;
        sum       = {1'b0, cnt} + 9'(wvalid & wready) + 9'(rready);
        if (state == IDLE) begin
            if (pick_hit) begin
                state_nxt         = BUSY;
                gnt_nxt           = '0;
                gnt_nxt[pick_idx] = 1'b1;
                cnt_nxt           = '0;
            end
        end else if (!req[gidx] || sum >= MB) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            cnt_nxt = sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            cnt   <= cnt_nxt;
        end

    always_comb begin
        wvalid    = busy & ch_wvalid[gidx];
        rvalid    = busy & ch_rvalid[gidx];
        waddr     = busy ? ch_waddr[gidx*AW +: AW] : '0;
        wdata     = busy ? ch_wdata[gidx*DW +: DW] : '0;
        raddr     = busy ? ch_raddr[gidx*AW +: AW] : '0;
        ch_wready = '0;
        ch_rready = '0;
        ch_rdata  = '0;
        if (busy) begin
            ch_wready[gidx]          = wready;
            ch_rready[gidx]          = rready;
            ch_rdata[gidx*DW +: DW]  = rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (NCH=4, MAX_BURST=4).
// Round-robin scenarios run when MEM_ARBITER_RR_EN is defined; otherwise the rr_mode-ignored scenario runs.
module tb_mem_arbiter;
    localparam int NCH = 4, AW = 26, DW = 32, MB = 4;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [NCH-1:0]    ch_wvalid, ch_wready, ch_rvalid, ch_rready, gnt;
    logic [NCH*AW-1:0] ch_waddr, ch_raddr;
    logic [NCH*DW-1:0] ch_wdata, ch_rdata;
    logic              wvalid, wready, rvalid, rready, rr_mode, busy;
    logic [AW-1:0]     waddr, raddr;
    logic [DW-1:0]     wdata, rdata;
    logic [2:0]        sel;

    always #5 clk = ~clk;

    mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_wvalid(ch_wvalid), .ch_wready(ch_wready), .ch_waddr(ch_waddr), .ch_wdata(ch_wdata),
        .ch_rvalid(ch_rvalid), .ch_rready(ch_rready), .ch_raddr(ch_raddr), .ch_rdata(ch_rdata),
        .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
        .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
        .sel(sel), .rr_mode(rr_mode), .gnt(gnt), .busy(busy)
    );

    int total = 0, passed = 0;
    logic [255:0] gq[$], wq[$], rq[$];
    logic [NCH-1:0] prev_gnt = '0;

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic unexpected(input string nm, input logic [255:0] got);
        total++;
        $display("FAIL %s: got %h expected no event", nm, got);
    endtask

    function automatic logic [AW-1:0] wa(input int k);
        return AW'(26'h0A000 + k);
    endfunction
    function automatic logic [DW-1:0] wd(input int k);
        return 32'(32'hC0DE_0000 + k * 17);
    endfunction
    function automatic logic [AW-1:0] ra(input int k);
        return AW'(26'h1B000 + k);
    endfunction
    function automatic logic [255:0] wexp(input int k);
        return 256'({4'(1 << k), wa(k), wd(k)});
    endfunction
    function automatic logic [255:0] rexp(input int k, input logic [DW-1:0] d);
        logic [NCH*DW-1:0] bus;
        bus = '0;
        bus[k*DW +: DW] = d;
        return 256'({1'b1, 4'(1 << k), ra(k), bus});
    endfunction

    // Monitor: every grant change, write handshake and read-data pulse pops one expectation.
    always @(negedge clk) begin
        if (gnt !== prev_gnt) begin
            if (gq.size() == 0) unexpected("gnt_change", 256'(gnt));
            else check("gnt", 256'(gnt), gq.pop_front());
            prev_gnt = gnt;
        end
        if (wvalid && wready) begin
            if (wq.size() == 0) unexpected("write", 256'({ch_wready, waddr, wdata}));
            else check("write", 256'({ch_wready, waddr, wdata}), wq.pop_front());
        end
        if (|ch_rready) begin
            if (rq.size() == 0) unexpected("read", 256'({rvalid, ch_rready, raddr, ch_rdata}));
            else check("read", 256'({rvalid, ch_rready, raddr, ch_rdata}), rq.pop_front());
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pg(input logic [NCH-1:0] g);
        gq.push_back(256'(g));
    endtask

    task automatic pw(input int k, input int n);
        repeat (n) wq.push_back(wexp(k));
    endtask

    task automatic drain(input string nm);
        check(nm, 256'(gq.size() + wq.size() + rq.size()), 256'(0));
        gq.delete();
        wq.delete();
        rq.delete();
    endtask

    task automatic idle_inputs();
        ch_wvalid = '0;
        ch_rvalid = '0;
        wready    = 1'b0;
        rready    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rdata   = '0;
        sel     = '0;
        rr_mode = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            ch_waddr[k*AW +: AW] = wa(k);
            ch_wdata[k*DW +: DW] = wd(k);
            ch_raddr[k*AW +: AW] = ra(k);
        end

        // Reset forces idle even with every input active
        ch_wvalid = '1;
        ch_rvalid = '1;
        wready    = 1'b1;
        rready    = 1'b1;
        rdata     = 32'hFFFF_0000;
        step(2);
        check("rst_gnt", 256'(gnt), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_valids", 256'({wvalid, rvalid}), 256'(0));
        check("rst_addr", 256'({waddr, wdata, raddr}), 256'(0));
        check("rst_ch_ready", 256'({ch_wready, ch_rready}), 256'(0));
        check("rst_ch_rdata", 256'(ch_rdata), 256'(0));
        idle_inputs();
        rst_n = 1'b1;
        step();

        // Fixed sel=2, short write burst ended by the channel
        sel = 3'd2;
        wready = 1'b1;
        ch_wvalid = 4'b0100;
        pg(4'b0100); pw(2, 2); pg(4'b0000);
        check("fx_gnt_before_edge", 256'(gnt), 256'(0));
        step();
        check("fx_gnt_latency", 256'(gnt), 256'(4'b0100));
        check("fx_ch_wready", 256'(ch_wready), 256'(4'b0100));
        check("fx_waddr", 256'(waddr), 256'(wa(2)));
        step(2);
        ch_wvalid = '0;
        step(2);
        drain("drain_fixed");

        // MAX_BURST cut-off then exactly one idle cycle before re-grant
        sel = 3'd0;
        ch_wvalid = 4'b0001;
        pg(4'b0001); pw(0, 4); pg(4'b0000); pg(4'b0001); pg(4'b0000);
        step(6);
        ch_wvalid = '0;
        step(2);
        drain("drain_maxburst");

        // Simultaneous write and read completions count as two
        sel = 3'd1;
        rready = 1'b1;
        rdata = 32'h1234_5678;
        ch_wvalid = 4'b0010;
        ch_rvalid = 4'b0010;
        pg(4'b0010); pw(1, 2); pg(4'b0000);
        rq.push_back(rexp(1, 32'h1234_5678));
        rq.push_back(rexp(1, 32'h1234_5678));
        step(3);
        idle_inputs();
        step(2);
        drain("drain_dual");

        // sel change while busy only takes effect after the next idle
        sel = 3'd3;
        wready = 1'b1;
        ch_wvalid = 4'b1001;
        pg(4'b1000); pw(3, 4); pg(4'b0000); pg(4'b0001); pg(4'b0000);
        step();
        sel = 3'd0;
        step(5);
        ch_wvalid = '0;
        step(2);
        drain("drain_sel_hold");

        // Out-of-range sel grants nothing
        sel = 3'd5;
        ch_wvalid = '1;
        ch_rvalid = '1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("sel5_busy", 256'(busy), 256'(0));
        end
        idle_inputs();
        step();
        drain("drain_sel5");

`ifndef MEM_ARBITER_RR_EN
        // rr_mode is ignored when round-robin is not built
        rr_mode = 1'b1;
        sel = 3'd1;
        wready = 1'b1;
        ch_wvalid = '1;
        pg(4'b0010); pw(1, 1); pg(4'b0000);
        step(2);
        ch_wvalid = '0;
        step(2);
        drain("drain_rr_ignored");
        rr_mode = 1'b0;
`endif

        // Reset mid-burst drops everything immediately
        sel = 3'd3;
        wready = 1'b1;
        ch_wvalid = 4'b1000;
        pg(4'b1000); pw(3, 1); pg(4'b0000);
        step(2);
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", 256'(gnt), 256'(0));
        check("midrst_wvalid", 256'(wvalid), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        step();
        ch_wvalid = '0;
        rst_n = 1'b1;
        step(2);
        drain("drain_midrst");

`ifdef MEM_ARBITER_RR_EN
        // After reset, channel 0 wins over channel 3
        rr_mode = 1'b1;
        ch_wvalid = 4'b1001;
        pg(4'b0001); pw(0, 1); pg(4'b0000);
        step(2);
        ch_wvalid = '0;
        step(2);
        drain("drain_rr_first");

        // Channel 1 read, one data pulse, then the request drops
        wready = 1'b0;
        rdata = 32'hDEAD_BEEF;
        ch_rvalid = 4'b0010;
        pg(4'b0010); pg(4'b0000);
        rq.push_back(rexp(1, 32'hDEAD_BEEF));
        step();
        rready = 1'b1;
        step();
        rready = 1'b0;
        ch_rvalid = '0;
        step();
        check("rd_back_idle", 256'(busy), 256'(0));
        step();
        drain("drain_rr_read");

        // All four writing: 0,1,2,3,0 with four beats each
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wready = 1'b1;
        ch_wvalid = '1;
        for (int k = 0; k < NCH; k++) begin
            pg(4'(1 << k));
            pw(k, 4);
            pg(4'b0000);
        end
        pg(4'b0001); pg(4'b0000);
        step(21);
        ch_wvalid = '0;
        step(2);
        drain("drain_rr_rotation");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
